life_grid_engine: RTL and testbench

- Parametrised Game of Life engine: holds a COLS x ROWS cell grid and steps it one generation per command.
- Scans the grid sequentially, one cell per cycle, double-buffered, with selectable hard-edge or toroidal boundaries.
- Emits one VGA pixel-write (x, y, colour, plot) per changed cell, so it drives vga_adapter directly.
- Sits between the keyboard/mouse control FSM (set/step/clear commands) and vga_adapter (160x120 mode).

---
 rtl/life_grid_engine.sv | 270 +++++++++++++++++++++++++++
 tb/tb_life_grid_engine.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_engine.sv
// life_grid_engine
// Game of Life engine holding a COLS x ROWS grid. A step command walks every
// cell once in row-major order, building the next generation in a shadow
// grid from the committed one. A one-cycle commit then swaps the new grid in.
// Every cell that changes produces one pixel write, so the outputs can feed
// vga_adapter directly.

module life_grid_engine #(
    parameter int         COLS         = 16,
    parameter int         ROWS         = 12,
    parameter int         X_W          = 8,
    parameter int         Y_W          = 7,
    parameter int         WRAP         = 0,
    parameter logic [2:0] ALIVE_COLOUR = 3'b111,
    parameter logic [2:0] DEAD_COLOUR  = 3'b000
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           cmd_set,
    input  logic [X_W-1:0] set_x,
    input  logic [Y_W-1:0] set_y,
    input  logic           set_val,
    input  logic           cmd_step,
    input  logic           cmd_clear,
    output logic           busy,
    output logic           done,
    output logic           plot,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic [2:0]     out_colour,
    output logic [15:0]    gen_count,
    output logic [15:0]    alive_count
);

    localparam int CELLS = COLS * ROWS;
    localparam int IDX_W = $clog2(CELLS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(CELLS - 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [X_W-1:0]   scan_x_q, scan_x_d;
    logic [Y_W-1:0]   scan_y_q, scan_y_d;
    logic [CELLS-1:0] cur_q, cur_d;
    logic [CELLS-1:0] nxt_q, nxt_d;
    logic [15:0]      pop_q, pop_d;
    logic [15:0]      gen_q, gen_d;
    logic [15:0]      alive_q, alive_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             plot_q, plot_d;
    logic [X_W-1:0]   out_x_q, out_x_d;
    logic [Y_W-1:0]   out_y_q, out_y_d;
    logic [2:0]       out_colour_q, out_colour_d;

    logic [IDX_W-1:0] adv_idx;
    logic [X_W-1:0]   adv_x;
    logic [Y_W-1:0]   adv_y;
    logic [3:0]       n_count;
    logic             cell_now;
    logic             new_val;
    logic             set_in_range;
    logic [IDX_W-1:0] set_idx;

    // Next scan position: the x/y counters track idx so no divider is needed.
    always_comb begin
        adv_idx = idx_q + IDX_W'(1);
        if (scan_x_q == X_W'(COLS - 1)) begin
            adv_x = '0;
            adv_y = scan_y_q + Y_W'(1);
        end else begin
            adv_x = scan_x_q + X_W'(1);
            adv_y = scan_y_q;
        end
    end

    // Count the eight neighbours of the scanned cell in the committed grid,
    // treating off-grid cells as dead or wrapping them onto the opposite edge.
    always_comb begin
        int nx;
        int ny;
        nx      = 0;
        ny      = 0;
        n_count = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) begin
                    nx = int'(scan_x_q) + dx;
                    ny = int'(scan_y_q) + dy;
                    if (WRAP != 0) begin
                        if (nx < 0)          nx = COLS - 1;
                        else if (nx >= COLS) nx = 0;
                        if (ny < 0)          ny = ROWS - 1;
                        else if (ny >= ROWS) ny = 0;
                        n_count = n_count + {3'b000, cur_q[IDX_W'(ny * COLS + nx)]};
                    end else if (nx >= 0 && nx < COLS && ny >= 0 && ny < ROWS) begin
                        n_count = n_count + {3'b000, cur_q[IDX_W'(ny * COLS + nx)]};
                    end
                end
            end
        end
    end

    // Life rule for the scanned cell and address decode for single-cell writes.
    always_comb begin
        cell_now     = cur_q[idx_q];
        new_val      = (n_count == 4'd3) || (cell_now && (n_count == 4'd2));
        set_in_range = (int'(set_x) < COLS) && (int'(set_y) < ROWS);
        set_idx      = IDX_W'(int'(set_y) * COLS + int'(set_x));
    end

    // Control: command arbitration in IDLE, generation scan, commit and clear sweep.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        cur_d        = cur_q;
        nxt_d        = nxt_q;
        pop_d        = pop_q;
        gen_d        = gen_q;
        alive_d      = alive_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        plot_d       = 1'b0;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_colour_d = out_colour_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_clear) begin
                    state_d  = S_CLEAR;
                    idx_d    = '0;
                    scan_x_d = '0;
                    scan_y_d = '0;
                    busy_d   = 1'b1;
                end else if (cmd_set) begin
                    if (set_in_range) begin
                        cur_d[set_idx] = set_val;
                        if (cur_q[set_idx] != set_val) begin
                            alive_d = set_val ? (alive_q + 16'd1) : (alive_q - 16'd1);
                        end
                        plot_d       = 1'b1;
                        out_x_d      = set_x;
                        out_y_d      = set_y;
                        out_colour_d = set_val ? ALIVE_COLOUR : DEAD_COLOUR;
                    end
                end else if (cmd_step) begin
                    state_d  = S_SCAN;
                    idx_d    = '0;
                    scan_x_d = '0;
                    scan_y_d = '0;
                    pop_d    = '0;
                    busy_d   = 1'b1;
                end
            end

            S_SCAN: begin
                nxt_d[idx_q] = new_val;
                pop_d        = pop_q + {15'd0, new_val};
                if (new_val != cell_now) begin
                    plot_d       = 1'b1;
                    out_x_d      = scan_x_q;
                    out_y_d      = scan_y_q;
                    out_colour_d = new_val ? ALIVE_COLOUR : DEAD_COLOUR;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_COMMIT;
                    done_d  = 1'b1;
                end else begin
                    idx_d    = adv_idx;
                    scan_x_d = adv_x;
                    scan_y_d = adv_y;
                end
            end

            S_COMMIT: begin
                cur_d   = nxt_q;
                alive_d = pop_q;
                gen_d   = gen_q + 16'd1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            S_CLEAR: begin
                if (cell_now) begin
                    plot_d       = 1'b1;
                    out_x_d      = scan_x_q;
                    out_y_d      = scan_y_q;
                    out_colour_d = DEAD_COLOUR;
                end
                if (idx_q == PENULT_IDX) begin
                    done_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    cur_d   = '0;
                    nxt_d   = '0;
                    gen_d   = '0;
                    alive_d = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    idx_d    = adv_idx;
                    scan_x_d = adv_x;
                    scan_y_d = adv_y;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, both grids, counters and the registered pixel interface.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            cur_q        <= '0;
            nxt_q        <= '0;
            pop_q        <= '0;
            gen_q        <= '0;
            alive_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            plot_q       <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            cur_q        <= cur_d;
            nxt_q        <= nxt_d;
            pop_q        <= pop_d;
            gen_q        <= gen_d;
            alive_q      <= alive_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            plot_q       <= plot_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_colour_q <= out_colour_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign plot        = plot_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_colour  = out_colour_q;
    assign gen_count   = gen_q;
    assign alive_count = alive_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Testbench for life_grid_engine: one hard-edge and one toroidal instance
// driven in lockstep, each compared against a grid-level Life model.

module tb_life_grid_engine;

    localparam int COLS  = 16;
    localparam int ROWS  = 12;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int CELLS = COLS * ROWS;

    logic clock = 1'b0;
    logic reset_n, cmd_set, cmd_step, cmd_clear, set_val;
    logic [X_W-1:0] set_x;
    logic [Y_W-1:0] set_y;

    logic           busy_w  [2];
    logic           done_w  [2];
    logic           plot_w  [2];
    logic [X_W-1:0] ox      [2];
    logic [Y_W-1:0] oy      [2];
    logic [2:0]     oc      [2];
    logic [15:0]    gen_w   [2];
    logic [15:0]    alive_w [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int pq0[$];
    int pq1[$];

    bit m_cur [2][ROWS][COLS];
    int m_exp [2][ROWS][COLS];
    int m_gen;

    life_grid_engine #(.COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .WRAP(0)) dut_flat (
        .clock(clock), .reset_n(reset_n), .cmd_set(cmd_set), .set_x(set_x), .set_y(set_y),
        .set_val(set_val), .cmd_step(cmd_step), .cmd_clear(cmd_clear), .busy(busy_w[0]),
        .done(done_w[0]), .plot(plot_w[0]), .out_x(ox[0]), .out_y(oy[0]), .out_colour(oc[0]),
        .gen_count(gen_w[0]), .alive_count(alive_w[0]));

    life_grid_engine #(.COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .WRAP(1)) dut_torus (
        .clock(clock), .reset_n(reset_n), .cmd_set(cmd_set), .set_x(set_x), .set_y(set_y),
        .set_val(set_val), .cmd_step(cmd_step), .cmd_clear(cmd_clear), .busy(busy_w[1]),
        .done(done_w[1]), .plot(plot_w[1]), .out_x(ox[1]), .out_y(oy[1]), .out_colour(oc[1]),
        .gen_count(gen_w[1]), .alive_count(alive_w[1]));

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every pixel write of both instances as x*4096 + y*16 + colour.
    always @(negedge clock) begin
        if (plot_w[0] === 1'b1) pq0.push_back(int'(ox[0]) * 4096 + int'(oy[0]) * 16 + int'(oc[0]));
        if (plot_w[1] === 1'b1) pq1.push_back(int'(ox[1]) * 4096 + int'(oy[1]) * 16 + int'(oc[1]));
    end

    function automatic void model_reset();
        for (int w = 0; w < 2; w++)
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++) begin
                    m_cur[w][y][x] = 1'b0;
                    m_exp[w][y][x] = -1;
                end
        m_gen = 0;
    endfunction

    function automatic int model_alive(input int w);
        int n = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                n += int'(m_cur[w][y][x]);
        return n;
    endfunction

    // One generation of Conway's rules on the model grids; records the expected plots.
    function automatic void model_step();
        bit nxt [ROWS][COLS];
        int n, xx, yy;
        bit nv;
        for (int w = 0; w < 2; w++) begin
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++) begin
                    n = 0;
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) begin
                            if (dx == 0 && dy == 0) continue;
                            xx = x + dx;
                            yy = y + dy;
                            if (w == 1) begin
                                xx = (xx + COLS) % COLS;
                                yy = (yy + ROWS) % ROWS;
                                n += int'(m_cur[w][yy][xx]);
                            end else if (xx >= 0 && xx < COLS && yy >= 0 && yy < ROWS) begin
                                n += int'(m_cur[w][yy][xx]);
                            end
                        end
                    nv = (n == 3) || (m_cur[w][y][x] && n == 2);
                    nxt[y][x] = nv;
                    m_exp[w][y][x] = (nv != m_cur[w][y][x]) ? (nv ? 7 : 0) : -1;
                end
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++)
                    m_cur[w][y][x] = nxt[y][x];
        end
        m_gen = (m_gen + 1) % 65536;
    endfunction

    function automatic void model_clear();
        for (int w = 0; w < 2; w++)
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++) begin
                    m_exp[w][y][x] = m_cur[w][y][x] ? 0 : -1;
                    m_cur[w][y][x] = 1'b0;
                end
        m_gen = 0;
    endfunction

    // Number of recorded plots that do not match the expected set, plus expected ones never seen.
    function automatic int count_bad(input int w, input int q[$]);
        int exp_l [ROWS][COLS];
        int bad = 0;
        int x, y, c;
        for (int yy = 0; yy < ROWS; yy++)
            for (int xx = 0; xx < COLS; xx++)
                exp_l[yy][xx] = m_exp[w][yy][xx];
        foreach (q[i]) begin
            x = q[i] / 4096;
            y = (q[i] / 16) % 256;
            c = q[i] % 16;
            if (x >= COLS || y >= ROWS) bad++;
            else if (exp_l[y][x] != c) bad++;
            else exp_l[y][x] = -1;
        end
        for (int yy = 0; yy < ROWS; yy++)
            for (int xx = 0; xx < COLS; xx++)
                if (exp_l[yy][xx] != -1) bad++;
        return bad;
    endfunction

    // Issue a clear and/or step, optionally poke cmd_set mid-run, and wait (bounded) for done.
    task automatic launch(input bit do_clear, input bit do_step, input int set_at, output int lat);
        int start;
        pq0.delete();
        pq1.delete();
        @(negedge clock);
        cmd_clear = do_clear;
        cmd_step  = do_step;
        start     = cyc;
        @(negedge clock);
        cmd_clear = 1'b0;
        cmd_step  = 1'b0;
        lat = -1;
        for (int i = 1; i < 2 * CELLS + 20; i++) begin
            cmd_set = (i == set_at);
            if (done_w[0] === 1'b1) begin
                lat = cyc - start;
                break;
            end
            @(negedge clock);
        end
        cmd_set = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic do_set(input int x, input int y, input bit v);
        pq0.delete();
        pq1.delete();
        @(negedge clock);
        set_x   = X_W'(x);
        set_y   = Y_W'(y);
        set_val = v;
        cmd_set = 1'b1;
        @(negedge clock);
        cmd_set = 1'b0;
        @(negedge clock);
        if (x < COLS && y < ROWS) begin
            m_cur[0][y][x] = v;
            m_cur[1][y][x] = v;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_set = 1'b0; cmd_step = 1'b0; cmd_clear = 1'b0;
        set_x = '0; set_y = '0; set_val = 1'b0;
        model_reset();
        #12;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if ({busy_w[w], done_w[w], plot_w[w], ox[w], oy[w], oc[w], gen_w[w], alive_w[w]} !== 53'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs dut%0d got %h want 0", w,
                         {busy_w[w], done_w[w], plot_w[w], ox[w], oy[w], oc[w], gen_w[w], alive_w[w]});
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_blinker();
        int lat;
        do_set(5, 5, 1'b1);
        checks++;
        if (pq0.size() !== 1 || pq0[0] !== 5 * 4096 + 5 * 16 + 7) begin
            errors++;
            $display("[TB] FAIL set_plot size %0d first %0d want 1 %0d", pq0.size(),
                     (pq0.size() > 0) ? pq0[0] : -1, 5 * 4096 + 5 * 16 + 7);
        end
        do_set(6, 5, 1'b1);
        do_set(7, 5, 1'b1);
        checks++;
        if (alive_w[0] !== 16'd3 || alive_w[1] !== 16'd3) begin
            errors++;
            $display("[TB] FAIL set_alive got %0d/%0d want 3", alive_w[0], alive_w[1]);
        end
        model_step();
        launch(1'b0, 1'b1, -1, lat);
        checks++;
        if (lat !== CELLS + 1) begin
            errors++;
            $display("[TB] FAIL step_latency got %0d want %0d", lat, CELLS + 1);
        end
        checks++;
        if (pq0.size() !== 4) begin
            errors++;
            $display("[TB] FAIL blinker_plot_count got %0d want 4", pq0.size());
        end
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (count_bad(w, (w == 0) ? pq0 : pq1) !== 0) begin
                errors++;
                $display("[TB] FAIL blinker_plots dut%0d bad %0d want 0", w, count_bad(w, (w == 0) ? pq0 : pq1));
            end
        end
        checks++;
        if (gen_w[0] !== 16'(m_gen) || alive_w[0] !== 16'(model_alive(0))) begin
            errors++;
            $display("[TB] FAIL blinker_counts gen %0d alive %0d want %0d %0d",
                     gen_w[0], alive_w[0], m_gen, model_alive(0));
        end
    endtask

    task automatic test_block();
        int lat;
        model_clear();
        launch(1'b1, 1'b0, -1, lat);
        checks++;
        if (lat !== CELLS) begin
            errors++;
            $display("[TB] FAIL clear_latency got %0d want %0d", lat, CELLS);
        end
        do_set(0, 0, 1'b1);
        do_set(1, 0, 1'b1);
        do_set(0, 1, 1'b1);
        do_set(1, 1, 1'b1);
        for (int s = 0; s < 3; s++) begin
            model_step();
            launch(1'b0, 1'b1, -1, lat);
            checks++;
            if (pq0.size() !== 0 || pq1.size() !== 0 || alive_w[0] !== 16'd4) begin
                errors++;
                $display("[TB] FAIL block_still plots %0d/%0d alive %0d want 0/0 4",
                         pq0.size(), pq1.size(), alive_w[0]);
            end
        end
        checks++;
        if (gen_w[0] !== 16'd3 || gen_w[1] !== 16'd3) begin
            errors++;
            $display("[TB] FAIL block_gen got %0d/%0d want 3", gen_w[0], gen_w[1]);
        end
    endtask

    task automatic test_wrap();
        int lat;
        model_clear();
        launch(1'b1, 1'b0, -1, lat);
        do_set(15, 0, 1'b1);
        do_set(0, 0, 1'b1);
        do_set(1, 0, 1'b1);
        model_step();
        launch(1'b0, 1'b1, -1, lat);
        checks++;
        if (pq1.size() !== 4) begin
            errors++;
            $display("[TB] FAIL wrap_plot_count got %0d want 4", pq1.size());
        end
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (count_bad(w, (w == 0) ? pq0 : pq1) !== 0 || alive_w[w] !== 16'(model_alive(w))) begin
                errors++;
                $display("[TB] FAIL wrap_plots dut%0d bad %0d alive %0d want 0 %0d", w,
                         count_bad(w, (w == 0) ? pq0 : pq1), alive_w[w], model_alive(w));
            end
        end
    endtask

    task automatic test_commands();
        int lat;
        int alive_before;
        alive_before = model_alive(1);
        do_set(COLS, 3, 1'b1);
        do_set(3, ROWS, 1'b1);
        checks++;
        if (pq0.size() !== 0 || pq1.size() !== 0 || alive_w[1] !== 16'(alive_before)) begin
            errors++;
            $display("[TB] FAIL set_out_of_range plots %0d/%0d alive %0d want 0/0 %0d",
                     pq0.size(), pq1.size(), alive_w[1], alive_before);
        end
        set_x = X_W'(10); set_y = Y_W'(10); set_val = 1'b1;
        model_step();
        launch(1'b0, 1'b1, 20, lat);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (count_bad(w, (w == 0) ? pq0 : pq1) !== 0 || alive_w[w] !== 16'(model_alive(w))) begin
                errors++;
                $display("[TB] FAIL set_while_busy dut%0d bad %0d alive %0d want 0 %0d", w,
                         count_bad(w, (w == 0) ? pq0 : pq1), alive_w[w], model_alive(w));
            end
        end
        model_clear();
        launch(1'b1, 1'b1, -1, lat);
        checks++;
        if (lat !== CELLS || gen_w[1] !== 16'd0 || alive_w[1] !== 16'd0 || count_bad(1, pq1) !== 0) begin
            errors++;
            $display("[TB] FAIL clear_beats_step lat %0d gen %0d alive %0d bad %0d want %0d 0 0 0",
                     lat, gen_w[1], alive_w[1], count_bad(1, pq1), CELLS);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        for (int i = 0; i < 30; i++)
            do_set(int'($urandom_range(0, COLS - 1)), int'($urandom_range(0, ROWS - 1)), 1'b1);
        @(negedge clock);
        cmd_step = 1'b1;
        @(negedge clock);
        cmd_step = 1'b0;
        repeat (40) @(negedge clock);
        checks++;
        if (busy_w[0] !== 1'b1 || busy_w[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_mid_scan got %b/%b want 1", busy_w[0], busy_w[1]);
        end
        reset_n = 1'b0;
        #1;
        pq0.delete();
        pq1.delete();
        for (int w = 0; w < 2; w++) begin
            checks++;
            if ({busy_w[w], done_w[w], plot_w[w], ox[w], oy[w], oc[w], gen_w[w], alive_w[w]} !== 53'd0) begin
                errors++;
                $display("[TB] FAIL reset_mid_scan dut%0d got %h want 0", w,
                         {busy_w[w], done_w[w], plot_w[w], ox[w], oy[w], oc[w], gen_w[w], alive_w[w]});
            end
        end
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        checks++;
        if (pq0.size() + pq1.size() !== 0 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_plot_after_reset plots %0d busy %b want 0 0", pq0.size() + pq1.size(), busy_w[0]);
        end
        model_step();
        launch(1'b0, 1'b1, -1, lat);
        checks++;
        if (pq0.size() + pq1.size() !== 0 || gen_w[0] !== 16'd1 || gen_w[1] !== 16'd1) begin
            errors++;
            $display("[TB] FAIL empty_step plots %0d gen %0d/%0d want 0 1", pq0.size() + pq1.size(), gen_w[0], gen_w[1]);
        end
    endtask

    task automatic test_clear();
        int lat;
        do_set(2, 3, 1'b1);
        do_set(9, 0, 1'b1);
        do_set(15, 11, 1'b1);
        do_set(0, 7, 1'b1);
        do_set(8, 8, 1'b1);
        model_clear();
        launch(1'b1, 1'b0, -1, lat);
        checks++;
        if (lat !== CELLS || pq0.size() !== 5) begin
            errors++;
            $display("[TB] FAIL clear_five lat %0d plots %0d want %0d 5", lat, pq0.size(), CELLS);
        end
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (count_bad(w, (w == 0) ? pq0 : pq1) !== 0 || alive_w[w] !== 16'd0 || gen_w[w] !== 16'd0) begin
                errors++;
                $display("[TB] FAIL clear_result dut%0d bad %0d alive %0d gen %0d want 0 0 0", w,
                         count_bad(w, (w == 0) ? pq0 : pq1), alive_w[w], gen_w[w]);
            end
        end
    endtask

    task automatic test_random();
        int lat, x, y, want;
        bit v, inr;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 25; k++) begin
                x   = int'($urandom_range(0, COLS));
                y   = int'($urandom_range(0, ROWS));
                v   = ($urandom_range(0, 3) != 0);
                inr = (x < COLS) && (y < ROWS);
                do_set(x, y, v);
                want = inr ? (x * 4096 + y * 16 + (v ? 7 : 0)) : -1;
                checks++;
                if (pq0.size() !== (inr ? 1 : 0) || ((pq0.size() > 0) ? pq0[0] : -1) !== want
                    || alive_w[0] !== 16'(model_alive(0))) begin
                    errors++;
                    $display("[TB] FAIL random_set (%0d,%0d) plots %0d first %0d alive %0d want %0d %0d %0d",
                             x, y, pq0.size(), (pq0.size() > 0) ? pq0[0] : -1, alive_w[0],
                             inr ? 1 : 0, want, model_alive(0));
                end
            end
            for (int s = 0; s < 3; s++) begin
                model_step();
                launch(1'b0, 1'b1, -1, lat);
                for (int w = 0; w < 2; w++) begin
                    checks++;
                    if (count_bad(w, (w == 0) ? pq0 : pq1) !== 0 || alive_w[w] !== 16'(model_alive(w))
                        || gen_w[w] !== 16'(m_gen) || lat !== CELLS + 1) begin
                        errors++;
                        $display("[TB] FAIL random_step dut%0d bad %0d alive %0d gen %0d lat %0d want 0 %0d %0d %0d",
                                 w, count_bad(w, (w == 0) ? pq0 : pq1), alive_w[w], gen_w[w], lat,
                                 model_alive(w), m_gen, CELLS + 1);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block();
        test_wrap();
        test_commands();
        test_reset_mid_scan();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
